// File: rtl/decode_stage_pipe_if.sv
// Bundles the upstream handshake, writeback port and ID/EX outputs of the decode stage.
// The slave modport is the decode stage itself; the master modport is whatever drives it.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [1:0]        reg_dest;
    logic              reg_write;
    logic              wb_valid;
    logic [2:0]        wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_opcode;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_wsel;
    logic              out_write;
    logic              halted;
    logic              err;

    modport slave (
        input  in_valid, instr, reg_dest, reg_write,
        input  wb_valid, wb_sel, wb_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_opcode, out_rd1, out_rd2, out_imm, out_wsel, out_write,
        output halted, err
    );

    modport master (
        output in_valid, instr, reg_dest, reg_write,
        output wb_valid, wb_sel, wb_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_opcode, out_rd1, out_rd2, out_imm, out_wsel, out_write,
        input  halted, err
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: register file, busy-bit scoreboard with optional writeback
// bypass, field decode and an ID/EX output register with valid/ready handshakes.
module decode_stage_pipe #(
    parameter int DATA_W   = 16,
    parameter int LINK_REG = 7,
    parameter int BYPASS   = 1
) (
    input logic                clk,
    input logic                rst,
    decode_stage_pipe_if.slave bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [2:0] LINK_SEL  = 3'(LINK_REG);
    localparam logic       BYPASS_EN = (BYPASS != 0);

    function automatic logic [7:0] onehot8(input logic [2:0] sel);
        return 8'b0000_0001 << sel;
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [7:0]        busy_q, busy_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_opcode_q, out_opcode_d;
    logic [DATA_W-1:0] out_rd1_q, out_rd1_d;
    logic [DATA_W-1:0] out_rd2_q, out_rd2_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [2:0]        out_wsel_q, out_wsel_d;
    logic              out_write_q, out_write_d;

    logic [4:0]        opcode_s;
    logic [2:0]        rs_s, rt_s, rd_s, wsel_s;
    logic              byp_rs_s, byp_rt_s, stall_rs_s, stall_rt_s;
    logic [DATA_W-1:0] rd1_s, rd2_s, imm_s;
    logic              write_s, in_ready_s, accept_s;
    logic [7:0]        busy_set_s, busy_clr_s;

    // Field decode, hazard check, operand read with bypass and handshake
    always_comb begin
        opcode_s = bus.instr[15:11];
        rs_s     = bus.instr[10:8];
        rt_s     = bus.instr[7:5];
        rd_s     = bus.instr[4:2];
        imm_s    = {{(DATA_W-5){bus.instr[4]}}, bus.instr[4:0]};

        byp_rs_s   = BYPASS_EN && bus.wb_valid && (bus.wb_sel == rs_s);
        byp_rt_s   = BYPASS_EN && bus.wb_valid && (bus.wb_sel == rt_s);
        stall_rs_s = busy_q[rs_s] && !byp_rs_s;
        stall_rt_s = busy_q[rt_s] && !byp_rt_s;

        if (byp_rs_s) begin
            rd1_s = bus.wb_data;
        end else begin
            rd1_s = regs_q[rs_s];
        end
        if (byp_rt_s) begin
            rd2_s = bus.wb_data;
        end else begin
            rd2_s = regs_q[rt_s];
        end

        case (bus.reg_dest)
            2'd0:    wsel_s = rt_s;
            2'd1:    wsel_s = rs_s;
            2'd2:    wsel_s = rd_s;
            2'd3:    wsel_s = LINK_SEL;
            default: wsel_s = rt_s;
        endcase

        // Opcode zero is the halt; it never writes even if reg_write is set.
        write_s    = bus.reg_write && (opcode_s != 5'b00000);
        in_ready_s = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready)
                     && !stall_rs_s && !stall_rt_s;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Register file writes, scoreboard set/clear and sticky error
    always_comb begin
        regs_d     = regs_q;
        busy_clr_s = 8'b0000_0000;
        busy_set_s = 8'b0000_0000;
        err_d      = err_q;
        if (bus.wb_valid) begin
            regs_d[bus.wb_sel] = bus.wb_data;
            busy_clr_s         = onehot8(bus.wb_sel);
            err_d              = err_q | !busy_q[bus.wb_sel];
        end else begin
            busy_clr_s = 8'b0000_0000;
        end
        if (accept_s && write_s) begin
            busy_set_s = onehot8(wsel_s);
        end else begin
            busy_set_s = 8'b0000_0000;
        end
        // Set is applied after clear so a younger writer keeps the bit busy.
        busy_d = (busy_q & ~busy_clr_s) | busy_set_s;
    end

    // ID/EX register load, drain and hold
    always_comb begin
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_rd1_d    = out_rd1_q;
        out_rd2_d    = out_rd2_q;
        out_imm_d    = out_imm_q;
        out_wsel_d   = out_wsel_q;
        out_write_d  = out_write_q;
        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_opcode_d = opcode_s;
            out_rd1_d    = rd1_s;
            out_rd2_d    = rd2_s;
            out_imm_d    = imm_s;
            out_wsel_d   = wsel_s;
            out_write_d  = write_s;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Run/halt state transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept_s && (opcode_s == 5'b00000)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            busy_q       <= 8'b0000_0000;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= 5'b00000;
            out_rd1_q    <= {DATA_W{1'b0}};
            out_rd2_q    <= {DATA_W{1'b0}};
            out_imm_q    <= {DATA_W{1'b0}};
            out_wsel_q   <= 3'b000;
            out_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_rd1_q    <= out_rd1_d;
            out_rd2_q    <= out_rd2_d;
            out_imm_q    <= out_imm_d;
            out_wsel_q   <= out_wsel_d;
            out_write_q  <= out_write_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_opcode = out_opcode_q;
    assign bus.out_rd1    = out_rd1_q;
    assign bus.out_rd2    = out_rd2_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_wsel   = out_wsel_q;
    assign bus.out_write  = out_write_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scenarios for the decode stage followed by a randomized run checked
// against an instruction-level reference model.
module tb_decode_stage_pipe;
    localparam int DATA_W   = 16;
    localparam int LINK_REG = 7;
    localparam int BYPASS   = 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    decode_stage_pipe_if #(.DATA_W(DATA_W)) bus_if ();

    decode_stage_pipe #(.DATA_W(DATA_W), .LINK_REG(LINK_REG), .BYPASS(BYPASS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_regs [8];
    bit          m_busy [8];
    bit          m_ov, m_write, m_halt, m_err;
    logic [4:0]  m_op;
    logic [15:0] m_rd1, m_rd2, m_imm;
    logic [2:0]  m_wsel;

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [4:0] lo);
        return {op, rs, rt, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.in_valid  = 1'b0;
        bus_if.instr     = 16'h0000;
        bus_if.reg_dest  = 2'd0;
        bus_if.reg_write = 1'b0;
        bus_if.wb_valid  = 1'b0;
        bus_if.wb_sel    = 3'd0;
        bus_if.wb_data   = 16'h0000;
        bus_if.out_ready = 1'b1;
    endtask

    task automatic apply_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_busy[i] = 1'b0;
        end
        m_ov = 1'b0; m_write = 1'b0; m_halt = 1'b0; m_err = 1'b0;
        m_op = 5'd0; m_rd1 = 16'h0; m_rd2 = 16'h0; m_imm = 16'h0; m_wsel = 3'd0;
    endtask

    function automatic bit m_fwd(input logic [2:0] s);
        return (BYPASS != 0) && bus_if.wb_valid && (bus_if.wb_sel == s);
    endfunction

    function automatic bit m_ready();
        logic [2:0] rs = bus_if.instr[10:8];
        logic [2:0] rt = bus_if.instr[7:5];
        bit waiting = (m_busy[rs] && !m_fwd(rs)) || (m_busy[rt] && !m_fwd(rt));
        return !m_halt && (!m_ov || bus_if.out_ready) && !waiting;
    endfunction

    // Advance the model by one clock using the current input values.
    task automatic m_step(output bit acc);
        logic [2:0]  rs = bus_if.instr[10:8];
        logic [2:0]  rt = bus_if.instr[7:5];
        logic [2:0]  dsel [4];
        logic [15:0] v1, v2;
        int          imm;
        acc = bus_if.in_valid && m_ready();
        v1  = m_fwd(rs) ? bus_if.wb_data : m_regs[rs];
        v2  = m_fwd(rt) ? bus_if.wb_data : m_regs[rt];
        dsel[0] = rt; dsel[1] = rs; dsel[2] = bus_if.instr[4:2]; dsel[3] = 3'(LINK_REG);
        imm = int'(bus_if.instr[4:0]);
        if (imm >= 16) imm = imm - 32;
        if (bus_if.wb_valid) begin
            if (!m_busy[bus_if.wb_sel]) m_err = 1'b1;
            m_regs[bus_if.wb_sel] = bus_if.wb_data;
            m_busy[bus_if.wb_sel] = 1'b0;
        end
        if (acc) begin
            m_ov    = 1'b1;
            m_op    = bus_if.instr[15:11];
            m_rd1   = v1;
            m_rd2   = v2;
            m_imm   = 16'(imm);
            m_wsel  = dsel[bus_if.reg_dest];
            m_write = bus_if.reg_write && (m_op != 5'd0);
            if (m_write) m_busy[m_wsel] = 1'b1;
            if (m_op == 5'd0) m_halt = 1'b1;
        end else if (m_ov && bus_if.out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #12;
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b exp 0", bus_if.out_valid); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", bus_if.out_valid); end
        checks++; if (bus_if.out_opcode !== 5'd0) begin errors++; $display("FAIL rst_opcode: got %h exp 0", bus_if.out_opcode); end
        checks++; if ({bus_if.out_rd1, bus_if.out_rd2, bus_if.out_imm} !== 48'h0) begin errors++; $display("FAIL rst_data: got %h %h %h exp 0", bus_if.out_rd1, bus_if.out_rd2, bus_if.out_imm); end
        checks++; if ({bus_if.out_wsel, bus_if.out_write} !== 4'h0) begin errors++; $display("FAIL rst_wsel_write: got %h %b exp 0", bus_if.out_wsel, bus_if.out_write); end
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", bus_if.in_ready); end
        checks++; if ({bus_if.halted, bus_if.err} !== 2'b00) begin errors++; $display("FAIL rst_halt_err: got %b%b exp 00", bus_if.halted, bus_if.err); end
    endtask

    task automatic test_imm_sign_extend();
        bus_if.in_valid = 1'b1; bus_if.instr = 16'h4A3F; bus_if.reg_dest = 2'd0; bus_if.reg_write = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL imm_valid: got %b exp 1", bus_if.out_valid); end
        checks++; if (bus_if.out_opcode !== 5'b01001) begin errors++; $display("FAIL imm_opcode: got %b exp 01001", bus_if.out_opcode); end
        checks++; if (bus_if.out_wsel !== 3'd1) begin errors++; $display("FAIL imm_wsel: got %0d exp 1", bus_if.out_wsel); end
        checks++; if (bus_if.out_imm !== 16'hFFFF) begin errors++; $display("FAIL imm_value: got %h exp ffff", bus_if.out_imm); end
        checks++; if (bus_if.out_write !== 1'b1) begin errors++; $display("FAIL imm_write: got %b exp 1", bus_if.out_write); end
        bus_if.instr = mk(5'd1, 3'd1, 3'd0, 5'd0);
        #1;
        checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL imm_busy_rs: got in_ready %b exp 0", bus_if.in_ready); end
        bus_if.instr = mk(5'd1, 3'd0, 3'd1, 5'd0);
        #1;
        checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL imm_busy_rt: got in_ready %b exp 0", bus_if.in_ready); end
        tick();
    endtask

    task automatic test_raw_bypass();
        logic exp_rdy = (BYPASS != 0);
        int   exp_wait = (BYPASS != 0) ? 0 : 1;
        int   n = 0;
        bus_if.in_valid = 1'b1; bus_if.instr = mk(5'd2, 3'd1, 3'd0, 5'd0); bus_if.reg_write = 1'b0;
        #1;
        checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got in_ready %b exp 0", bus_if.in_ready); end
        tick();
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain: got out_valid %b exp 0", bus_if.out_valid); end
        bus_if.wb_valid = 1'b1; bus_if.wb_sel = 3'd1; bus_if.wb_data = 16'h1234;
        #1;
        checks++; if (bus_if.in_ready !== exp_rdy) begin errors++; $display("FAIL raw_wb_ready: got %b exp %b", bus_if.in_ready, exp_rdy); end
        tick();
        bus_if.wb_valid = 1'b0;
        while (!bus_if.out_valid && n < 4) begin
            n++;
            tick();
        end
        bus_if.in_valid = 1'b0;
        checks++; if (n !== exp_wait) begin errors++; $display("FAIL raw_latency: got %0d exp %0d extra cycles", n, exp_wait); end
        checks++; if (bus_if.out_rd1 !== 16'h1234) begin errors++; $display("FAIL raw_rd1: got %h exp 1234", bus_if.out_rd1); end
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL raw_err: got %b exp 0", bus_if.err); end
        tick();
    endtask

    task automatic test_backpressure();
        bus_if.in_valid = 1'b1; bus_if.instr = mk(5'd3, 3'd2, 3'd3, 5'b01010);
        bus_if.reg_dest = 2'd2; bus_if.reg_write = 1'b1; bus_if.out_ready = 1'b0;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b exp 1", bus_if.in_ready); end
        tick();
        bus_if.instr = mk(5'd4, 3'd4, 3'd5, 5'b10000); bus_if.reg_dest = 2'd1; bus_if.reg_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready c%0d: got %b exp 0", k, bus_if.in_ready); end
            tick();
            checks++; if ({bus_if.out_valid, bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write} !== {1'b1, 5'd3, 3'd2, 1'b1}) begin errors++; $display("FAIL bp_hold_ctl c%0d: got %b %h %h %b exp 1 03 2 1", k, bus_if.out_valid, bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write); end
            checks++; if (bus_if.out_imm !== 16'h000A) begin errors++; $display("FAIL bp_hold_imm c%0d: got %h exp 000a", k, bus_if.out_imm); end
        end
        bus_if.out_ready = 1'b1;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", bus_if.in_ready); end
        tick();
        bus_if.in_valid = 1'b0;
        checks++; if ({bus_if.out_valid, bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write} !== {1'b1, 5'd4, 3'd4, 1'b0}) begin errors++; $display("FAIL bp_second: got %b %h %h %b exp 1 04 4 0", bus_if.out_valid, bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write); end
        checks++; if (bus_if.out_imm !== 16'hFFF0) begin errors++; $display("FAIL bp_second_imm: got %h exp fff0", bus_if.out_imm); end
        tick();
    endtask

    task automatic test_jal_writeback();
        bus_if.in_valid = 1'b1; bus_if.instr = mk(5'd6, 3'd0, 3'd0, 5'd0);
        bus_if.reg_dest = 2'd3; bus_if.reg_write = 1'b1;
        tick();
        bus_if.instr = mk(5'd7, 3'd0, 3'd0, 5'd0);
        bus_if.wb_valid = 1'b1; bus_if.wb_sel = 3'd7; bus_if.wb_data = 16'hBEEF;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL jal_ready: got %b exp 1", bus_if.in_ready); end
        tick();
        bus_if.wb_valid = 1'b0; bus_if.in_valid = 1'b0;
        checks++; if ({bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write} !== {5'd7, 3'd7, 1'b1}) begin errors++; $display("FAIL jal_out: got %h %h %b exp 07 7 1", bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write); end
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL jal_err: got %b exp 0", bus_if.err); end
        bus_if.instr = mk(5'd1, 3'd7, 3'd0, 5'd0);
        #1;
        checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL jal_busy7: got in_ready %b exp 0", bus_if.in_ready); end
        bus_if.wb_valid = 1'b1; bus_if.wb_sel = 3'd7;
        tick();
        bus_if.wb_sel = 3'd2;
        tick();
        bus_if.wb_valid = 1'b0;
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL jal_clear_err: got %b exp 0", bus_if.err); end
        tick();
    endtask

    task automatic test_halt_error();
        bus_if.in_valid = 1'b1; bus_if.instr = 16'h0000; bus_if.reg_dest = 2'd0; bus_if.reg_write = 1'b1;
        tick();
        checks++; if ({bus_if.out_valid, bus_if.out_opcode, bus_if.out_write} !== {1'b1, 5'd0, 1'b0}) begin errors++; $display("FAIL halt_out: got %b %h %b exp 1 00 0", bus_if.out_valid, bus_if.out_opcode, bus_if.out_write); end
        checks++; if (bus_if.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b exp 1", bus_if.halted); end
        bus_if.instr = mk(5'd1, 3'd3, 3'd4, 5'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready c%0d: got %b exp 0", k, bus_if.in_ready); end
            tick();
        end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL halt_no_accept: got out_valid %b exp 0", bus_if.out_valid); end
        bus_if.in_valid = 1'b0;
        bus_if.wb_valid = 1'b1; bus_if.wb_sel = 3'd5; bus_if.wb_data = 16'h5A5A;
        tick();
        bus_if.wb_valid = 1'b0;
        checks++; if (bus_if.err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b exp 1", bus_if.err); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({bus_if.halted, bus_if.err} !== 2'b00) begin errors++; $display("FAIL async_rst_clear: got %b%b exp 00", bus_if.halted, bus_if.err); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b exp 1", bus_if.in_ready); end
    endtask

    task automatic test_random();
        bit held = 1'b0;
        bit acc;
        apply_reset();
        m_reset();
        for (int c = 0; c < 800; c++) begin
            if (!held) begin
                bus_if.in_valid  = ($urandom_range(0, 3) != 0);
                bus_if.instr     = mk(5'($urandom_range(1, 31)), 3'($urandom_range(0, 7)),
                                      3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                bus_if.reg_dest  = 2'($urandom_range(0, 3));
                bus_if.reg_write = 1'($urandom_range(0, 1));
            end
            bus_if.wb_valid = ($urandom_range(0, 9) < 4);
            bus_if.wb_sel   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) != 0) begin
                bit found = 1'b0;
                int start = int'(bus_if.wb_sel);
                for (int k = 0; k < 8; k++) begin
                    if (!found && m_busy[(start + k) % 8]) begin
                        found = 1'b1;
                        bus_if.wb_sel = 3'((start + k) % 8);
                    end
                end
            end
            bus_if.wb_data   = 16'($urandom);
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++; if (bus_if.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b exp %b", c, bus_if.in_ready, m_ready()); end
            m_step(acc);
            held = bus_if.in_valid && !acc;
            tick();
            checks++; if (bus_if.out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, bus_if.out_valid, m_ov); end
            checks++; if ({bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write} !== {m_op, m_wsel, m_write}) begin errors++; $display("FAIL rnd_ctl c%0d: got %h %h %b exp %h %h %b", c, bus_if.out_opcode, bus_if.out_wsel, bus_if.out_write, m_op, m_wsel, m_write); end
            checks++; if (bus_if.out_rd1 !== m_rd1) begin errors++; $display("FAIL rnd_rd1 c%0d: got %h exp %h", c, bus_if.out_rd1, m_rd1); end
            checks++; if (bus_if.out_rd2 !== m_rd2) begin errors++; $display("FAIL rnd_rd2 c%0d: got %h exp %h", c, bus_if.out_rd2, m_rd2); end
            checks++; if (bus_if.out_imm !== m_imm) begin errors++; $display("FAIL rnd_imm c%0d: got %h exp %h", c, bus_if.out_imm, m_imm); end
            checks++; if ({bus_if.halted, bus_if.err} !== {m_halt, m_err}) begin errors++; $display("FAIL rnd_flags c%0d: got %b%b exp %b%b", c, bus_if.halted, bus_if.err, m_halt, m_err); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_imm_sign_extend();
        test_raw_bypass();
        test_backpressure();
        test_jal_writeback();
        test_halt_error();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
